// File: rtl/sc_game_progress_tracker.sv
//-----------------------------------------------------------------------------
// sc_game_progress_tracker
//
// Gameplay bookkeeping stage sitting directly upstream of the main game state
// machine. It counts nests filled and lives remaining from low-active gameplay
// event strobes, raises the main FSM's "nests complete" / "lives lost" inputs
// (both low-active), and holds each one until the FSM acknowledges it through
// its changeLevel / load outputs.
//
// Ports
//   SC_STATEMACHINE_MAIN_CLOCK_50     in   system clock, rising edge
//   SC_STATEMACHINE_MAIN_RESET_InHigh in   asynchronous active-high reset
//   clear_InLow                       in   low = wipe everything, go idle
//   load_InLow                        in   low = new game / ack of lives-out
//   changeLevel_InLow                 in   low = next level / ack of nests-done
//   nestReached_InLow                 in   low while player sits in a nest
//   playerHit_InLow                   in   low while player is hit
//   nidosCompletos_OutLow             out  low = all nests of the level filled
//   perdioVidas_OutLow                out  low = lives exhausted
//   lives_OutBUS                      out  lives remaining
//   nests_OutBUS                      out  nests filled this level
//-----------------------------------------------------------------------------
module sc_game_progress_tracker #(
    parameter int NEST_COUNT  = 5,
    parameter int NEST_WIDTH  = 3,
    parameter int LIVES_INIT  = 3,
    parameter int LIVES_WIDTH = 2
) (
    input  logic                   SC_STATEMACHINE_MAIN_CLOCK_50,
    input  logic                   SC_STATEMACHINE_MAIN_RESET_InHigh,
    input  logic                   clear_InLow,
    input  logic                   load_InLow,
    input  logic                   changeLevel_InLow,
    input  logic                   nestReached_InLow,
    input  logic                   playerHit_InLow,
    output logic                   nidosCompletos_OutLow,
    output logic                   perdioVidas_OutLow,
    output logic [LIVES_WIDTH-1:0] lives_OutBUS,
    output logic [NEST_WIDTH-1:0]  nests_OutBUS
);

    localparam logic [NEST_WIDTH-1:0]  NEST_MAX   = NEST_WIDTH'(NEST_COUNT);
    localparam logic [LIVES_WIDTH-1:0] LIVES_LOAD = LIVES_WIDTH'(LIVES_INIT);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_PLAY       = 2'd1,
        ST_NESTS_DONE = 2'd2,
        ST_LIVES_OUT  = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [LIVES_WIDTH-1:0]   lives_q, lives_d;
    logic [NEST_WIDTH-1:0]    nests_q, nests_d;
    logic                     nidos_q, nidos_d;
    logic                     perdio_q, perdio_d;
    logic                     nest_prev_q, nest_prev_d;
    logic                     hit_prev_q, hit_prev_d;

    logic                     nest_ev;
    logic                     hit_ev;
    logic [NEST_WIDTH-1:0]    nests_inc;
    logic [LIVES_WIDTH-1:0]   lives_dec;

    // Nest counter saturates at the level target; it can never wrap.
    function automatic logic [NEST_WIDTH-1:0] sat_inc_nests(
        input logic [NEST_WIDTH-1:0] val
    );
        if (val < NEST_MAX) begin
            sat_inc_nests = val + NEST_WIDTH'(1);
        end else begin
            sat_inc_nests = val;
        end
    endfunction

    // Lives counter floors at zero.
    function automatic logic [LIVES_WIDTH-1:0] sat_dec_lives(
        input logic [LIVES_WIDTH-1:0] val
    );
        if (val != '0) begin
            sat_dec_lives = val - LIVES_WIDTH'(1);
        end else begin
            sat_dec_lives = '0;
        end
    endfunction

    // Falling-edge detection: previous sample high, current sample low.
    // A strobe held low therefore counts exactly once.
    assign nest_ev   = nest_prev_q & ~nestReached_InLow;
    assign hit_ev    = hit_prev_q  & ~playerHit_InLow;
    assign nests_inc = sat_inc_nests(nests_q);
    assign lives_dec = sat_dec_lives(lives_q);

    //-------------------------------------------------------------------------
    // State / counter registers
    //-------------------------------------------------------------------------
    always_ff @(posedge SC_STATEMACHINE_MAIN_CLOCK_50 or
                posedge SC_STATEMACHINE_MAIN_RESET_InHigh) begin
        if (SC_STATEMACHINE_MAIN_RESET_InHigh) begin
            state_q     <= ST_IDLE;
            lives_q     <= '0;
            nests_q     <= '0;
            nidos_q     <= 1'b1;
            perdio_q    <= 1'b1;
            nest_prev_q <= 1'b1;
            hit_prev_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            lives_q     <= lives_d;
            nests_q     <= nests_d;
            nidos_q     <= nidos_d;
            perdio_q    <= perdio_d;
            nest_prev_q <= nest_prev_d;
            hit_prev_q  <= hit_prev_d;
        end
    end

    //-------------------------------------------------------------------------
    // Next-state logic
    //-------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        lives_d     = lives_q;
        nests_d     = nests_q;
        nidos_d     = nidos_q;
        perdio_d    = perdio_q;
        // Edge history tracks the inputs every cycle, whatever the state.
        nest_prev_d = nestReached_InLow;
        hit_prev_d  = playerHit_InLow;

        if (!clear_InLow) begin
            state_d  = ST_IDLE;
            lives_d  = '0;
            nests_d  = '0;
            nidos_d  = 1'b1;
            perdio_d = 1'b1;
        end else if (!load_InLow) begin
            state_d  = ST_PLAY;
            lives_d  = LIVES_LOAD;
            nests_d  = '0;
            nidos_d  = 1'b1;
            perdio_d = 1'b1;
        end else if (!changeLevel_InLow &&
                     (state_q == ST_PLAY || state_q == ST_NESTS_DONE)) begin
            // New level: lives carry over, nest count restarts.
            state_d = ST_PLAY;
            nests_d = '0;
            nidos_d = 1'b1;
        end else begin
            unique case (state_q)
                ST_PLAY: begin
                    if (nest_ev && nests_inc == NEST_MAX) begin
                        // Completing the level takes precedence; a hit in
                        // the same cycle is discarded.
                        state_d = ST_NESTS_DONE;
                        nests_d = nests_inc;
                        nidos_d = 1'b0;
                    end else begin
                        if (nest_ev) begin
                            nests_d = nests_inc;
                        end
                        if (hit_ev) begin
                            lives_d = lives_dec;
                            if (lives_dec == '0) begin
                                state_d  = ST_LIVES_OUT;
                                perdio_d = 1'b0;
                            end
                        end
                    end
                end
                ST_NESTS_DONE: begin
                    nidos_d = 1'b0;
                end
                ST_LIVES_OUT: begin
                    lives_d  = '0;
                    perdio_d = 1'b0;
                end
                default: begin
                    // ST_IDLE: events ignored until a load arrives.
                end
            endcase
        end
    end

    assign nidosCompletos_OutLow = nidos_q;
    assign perdioVidas_OutLow    = perdio_q;
    assign lives_OutBUS          = lives_q;
    assign nests_OutBUS          = nests_q;

endmodule

// File: tb/tb_sc_game_progress_tracker.sv
module tb_sc_game_progress_tracker;

    logic       clk;
    logic       rst;
    logic       clr_n, ld_n, cl_n, nest_n, hit_n;
    logic       nidos_n, perdio_n;
    logic [1:0] lives;
    logic [2:0] nests;

    int checks = 0;
    int errors = 0;

    // Reference model: mode 0=idle, 1=playing, 2=level complete, 3=game over
    int m_mode, m_lives, m_nests;
    bit m_pn, m_ph;

    sc_game_progress_tracker #(
        .NEST_COUNT(5), .NEST_WIDTH(3), .LIVES_INIT(3), .LIVES_WIDTH(2)
    ) dut (
        .SC_STATEMACHINE_MAIN_CLOCK_50    (clk),
        .SC_STATEMACHINE_MAIN_RESET_InHigh(rst),
        .clear_InLow                      (clr_n),
        .load_InLow                       (ld_n),
        .changeLevel_InLow                (cl_n),
        .nestReached_InLow                (nest_n),
        .playerHit_InLow                  (hit_n),
        .nidosCompletos_OutLow            (nidos_n),
        .perdioVidas_OutLow               (perdio_n),
        .lives_OutBUS                     (lives),
        .nests_OutBUS                     (nests)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_lives = 0; m_nests = 0; m_pn = 1'b1; m_ph = 1'b1;
    endtask

    // Game rules applied to one clock edge with the inputs present before it.
    task automatic model_step(input bit c, input bit l, input bit g, input bit n, input bit h);
        bit nev, hev;
        nev = m_pn && !n;
        hev = m_ph && !h;
        m_pn = n;
        m_ph = h;
        if (!c) begin
            m_mode = 0; m_lives = 0; m_nests = 0;
        end else if (!l) begin
            m_mode = 1; m_lives = 3; m_nests = 0;
        end else if (!g && (m_mode == 1 || m_mode == 2)) begin
            m_mode = 1; m_nests = 0;
        end else if (m_mode == 1) begin
            if (nev) begin
                m_nests = m_nests + 1;
                if (m_nests == 5) m_mode = 2;
            end
            if (m_mode == 1 && hev) begin
                m_lives = m_lives - 1;
                if (m_lives == 0) m_mode = 3;
            end
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".lives"}, 32'(lives), 32'(m_lives));
        chk({tag, ".nests"}, 32'(nests), 32'(m_nests));
        chk({tag, ".nidos"}, 32'(nidos_n), (m_mode == 2) ? 32'd0 : 32'd1);
        chk({tag, ".perdio"}, 32'(perdio_n), (m_mode == 3) ? 32'd0 : 32'd1);
    endtask

    // One clock: drive inputs, clock edge, update model, sample #1 later.
    task automatic cyc(input string tag, input bit c, input bit l, input bit g,
                       input bit n, input bit h);
        clr_n = c; ld_n = l; cl_n = g; nest_n = n; hit_n = h;
        @(posedge clk);
        model_step(c, l, g, n, h);
        #1;
        check_model(tag);
    endtask

    task automatic idle(input string tag);
        cyc(tag, 1, 1, 1, 1, 1);
    endtask

    task automatic nest_pulse(input string tag, input int low_cycles);
        for (int i = 0; i < low_cycles; i++) cyc(tag, 1, 1, 1, 0, 1);
        idle(tag);
    endtask

    task automatic hit_pulse(input string tag);
        cyc(tag, 1, 1, 1, 1, 0);
        idle(tag);
    endtask

    task automatic do_load(input string tag);
        cyc(tag, 1, 0, 1, 1, 1);
        idle(tag);
    endtask

    initial begin
        clr_n = 1; ld_n = 1; cl_n = 1; nest_n = 1; hit_n = 1;
        rst = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst.lives", 32'(lives), 32'd0);
        chk("rst.nests", 32'(nests), 32'd0);
        chk("rst.nidos", 32'(nidos_n), 32'd1);
        chk("rst.perdio", 32'(perdio_n), 32'd1);
        rst = 1'b0;
        idle("post_rst");

        // New game
        cyc("load", 1, 0, 1, 1, 1);
        chk("load.lives3", 32'(lives), 32'd3);
        chk("load.nests0", 32'(nests), 32'd0);
        idle("load");

        // Five nest edges, the third held low for 10 cycles
        nest_pulse("nest1", 1);
        nest_pulse("nest2", 1);
        nest_pulse("nest3_held", 10);
        chk("nest.held_once", 32'(nests), 32'd3);
        nest_pulse("nest4", 1);
        cyc("nest5", 1, 1, 1, 0, 1);
        chk("nest5.flag_low", 32'(nidos_n), 32'd0);
        chk("nest5.count", 32'(nests), 32'd5);
        idle("nest5");
        nest_pulse("done.ignored_nest", 1);
        hit_pulse("done.ignored_hit");
        chk("done.lives_frozen", 32'(lives), 32'd3);
        cyc("chlvl", 1, 1, 0, 1, 1);
        chk("chlvl.flag_high", 32'(nidos_n), 32'd1);
        chk("chlvl.nests0", 32'(nests), 32'd0);
        chk("chlvl.lives3", 32'(lives), 32'd3);
        idle("chlvl");

        // Three hits -> game over
        hit_pulse("hit1");
        hit_pulse("hit2");
        cyc("hit3", 1, 1, 1, 1, 0);
        chk("hit3.flag_low", 32'(perdio_n), 32'd0);
        chk("hit3.lives0", 32'(lives), 32'd0);
        idle("hit3");
        nest_pulse("out.ignored_nest", 1);
        hit_pulse("out.ignored_hit");
        cyc("out.ignored_chlvl", 1, 1, 0, 1, 1);
        chk("out.still_low", 32'(perdio_n), 32'd0);
        cyc("out.load", 1, 0, 1, 1, 1);
        chk("out.load_lives", 32'(lives), 32'd3);
        chk("out.load_flag", 32'(perdio_n), 32'd1);
        idle("out.load");

        // nests=4, lives=1, simultaneous nest+hit -> level complete wins
        hit_pulse("s1.h"); hit_pulse("s1.h");
        for (int i = 0; i < 4; i++) nest_pulse("s1.n", 1);
        cyc("s1.both", 1, 1, 1, 0, 0);
        chk("s1.nests5", 32'(nests), 32'd5);
        chk("s1.lives1", 32'(lives), 32'd1);
        chk("s1.perdio_high", 32'(perdio_n), 32'd1);
        chk("s1.nidos_low", 32'(nidos_n), 32'd0);
        idle("s1");

        // nests=4, lives=2 -> hit discarded
        do_load("s2.load");
        hit_pulse("s2.h");
        for (int i = 0; i < 4; i++) nest_pulse("s2.n", 1);
        cyc("s2.both", 1, 1, 1, 0, 0);
        chk("s2.lives2", 32'(lives), 32'd2);
        idle("s2");

        // nests=2, lives=2 -> both applied, keeps playing
        do_load("s3.load");
        hit_pulse("s3.h");
        for (int i = 0; i < 2; i++) nest_pulse("s3.n", 1);
        cyc("s3.both", 1, 1, 1, 0, 0);
        chk("s3.nests3", 32'(nests), 32'd3);
        chk("s3.lives1", 32'(lives), 32'd1);
        chk("s3.nidos_high", 32'(nidos_n), 32'd1);
        idle("s3");

        // Asynchronous reset while level-complete flag is low
        for (int i = 0; i < 2; i++) nest_pulse("ar.n", 1);
        chk("ar.pre_flag", 32'(nidos_n), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("ar.flag", 32'(nidos_n), 32'd1);
        chk("ar.nests", 32'(nests), 32'd0);
        chk("ar.lives", 32'(lives), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        nest_pulse("ar.idle_nest", 1);
        hit_pulse("ar.idle_hit");
        chk("ar.idle_nests0", 32'(nests), 32'd0);

        // Clear concurrent with load -> idle wins
        do_load("cl.load");
        nest_pulse("cl.n", 1);
        cyc("cl.both", 0, 0, 1, 1, 1);
        chk("cl.lives0", 32'(lives), 32'd0);
        chk("cl.nests0", 32'(nests), 32'd0);
        idle("cl");

        // Randomized play against the reference model
        do_load("rnd.load");
        for (int i = 0; i < 1500; i++) begin
            bit c, l, g, n, h;
            c = ($urandom_range(0, 99) != 0);
            l = ($urandom_range(0, 39) != 0);
            g = ($urandom_range(0, 11) != 0);
            n = ($urandom_range(0, 2) != 0);
            h = ($urandom_range(0, 4) != 0);
            cyc("rnd", c, l, g, n, h);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
